// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and presents
// {instruction, PC_out, PC_branch_link} to IF/ID. Define IFETCH_PREFETCH_EN for a one-entry prefetch buffer.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instruction,
  output logic [63:0] PC_out,
  output logic [63:0] PC_branch_link
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef enum logic {S_REQ, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [XLEN-1:0]   link_q, link_d;
  logic              discard_q, discard_d;

  logic              consume_c;
  logic [XLEN-1:0]   pc_inc_c;
  logic [XLEN-1:0]   tgt_c;
  logic [1:0]        unused_tgt_bits;

`ifdef IFETCH_PREFETCH_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ILEN-1:0]   buf_instr_q, buf_instr_d;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
  logic              fetch_ok_c;
`endif

  assign consume_c       = valid_q & IF_ID_Write;
  assign pc_inc_c        = pc_q + STEP;
  assign tgt_c           = {branch_target[XLEN-1:2], 2'b00};
  assign unused_tgt_bits = branch_target[1:0];

  // Next-state and registered-output logic; a redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    link_d    = link_q;
    discard_d = discard_q;
`ifdef IFETCH_PREFETCH_EN
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    fetch_ok_c  = 1'b0;
`endif

    if (branch_taken) begin
      pc_d    = tgt_c;
      valid_d = 1'b0;
      state_d = S_REQ;
`ifdef IFETCH_PREFETCH_EN
      buf_valid_d = 1'b0;
`endif
      // An unanswered request cannot be withdrawn, so its response is marked for dropping.
      if (req_q && !imem_ack) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
        req_d     = 1'b1;
        addr_d    = tgt_c;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end else if (imem_ack) begin
            if (discard_q) begin
              discard_d = 1'b0;
              addr_d    = pc_q;
            end else begin
              instr_d  = imem_rdata;
              pc_out_d = pc_q;
              link_d   = pc_inc_c;
              valid_d  = 1'b1;
              pc_d     = pc_inc_c;
              state_d  = S_HOLD;
`ifdef IFETCH_PREFETCH_EN
              req_d    = 1'b1;
              addr_d   = pc_inc_c;
`else
              req_d    = 1'b0;
`endif
            end
          end
        end
        S_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
          fetch_ok_c = req_q & imem_ack;
          if (fetch_ok_c) begin
            pc_d = pc_inc_c;
          end
          if (consume_c) begin
            if (buf_valid_q) begin
              instr_d     = buf_instr_q;
              pc_out_d    = buf_pc_q;
              link_d      = buf_pc_q + STEP;
              buf_valid_d = fetch_ok_c;
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
            end else if (fetch_ok_c) begin
              instr_d  = imem_rdata;
              pc_out_d = pc_q;
              link_d   = pc_inc_c;
            end else begin
              valid_d = 1'b0;
              state_d = S_REQ;
            end
          end else if (fetch_ok_c) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
          end
          // Keep prefetching whenever the buffer will have room.
          req_d = ~buf_valid_d;
          if (fetch_ok_c || !req_q) begin
            addr_d = pc_d;
          end
`else
          if (consume_c) begin
            valid_d = 1'b0;
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
`endif
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_out_q  <= '0;
      link_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      link_q    <= link_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFETCH_PREFETCH_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end
`endif

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign fetch_valid    = valid_q;
  assign instruction    = instr_q;
  assign PC_out         = pc_out_q;
  assign PC_branch_link = link_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: wait-state memory model, consumed-instruction scoreboard
// driven by a sequential-stream-with-redirects reference model.
module tb_if_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IF_ID_Write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic [63:0] PC_out;
  logic [63:0] PC_branch_link;

  if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .IF_ID_Write(IF_ID_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .instruction(instruction),
    .PC_out(PC_out), .PC_branch_link(PC_branch_link)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] gen_pc = RST_PC;
  logic        redirect_pending = 1'b0;
  logic [63:0] redirect_tgt = '0;
  int          total = 0;
  int          bad = 0;
  int          n_consumed = 0;
  int          max_wait = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: random wait states per request, protocol checks on req/addr stability.
  initial begin : memory
    logic        new_req;
    logic [63:0] req_addr;
    int          wait_cnt;
    new_req = 1'b1;
    req_addr = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        imem_ack = 1'b0;
        new_req = 1'b1;
      end else begin
        if (imem_ack) new_req = 1'b1;
        if (imem_req) begin
          if (new_req) begin
            wait_cnt = $urandom_range(max_wait, 0);
            new_req = 1'b0;
            req_addr = imem_addr;
          end else begin
            chk("addr_stable", imem_addr, req_addr);
          end
          if (wait_cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(imem_addr);
          end else begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            wait_cnt--;
          end
        end else begin
          if (!new_req) chk("req_withdrawn", 64'(imem_req), 64'd1);
          imem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every consume, checks hold/flush behaviour.
  initial begin : monitor
    logic        have_prev, prev_valid, prev_cons, prev_br;
    logic [31:0] prev_ins;
    logic [63:0] prev_pc, prev_link;
    exp_t        e;
    have_prev = 1'b0;
    prev_valid = 1'b0; prev_cons = 1'b0; prev_br = 1'b0;
    prev_ins = '0; prev_pc = '0; prev_link = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && prev_br) chk("flush_on_branch", 64'(fetch_valid), 64'd0);
        if (have_prev && prev_valid && !prev_cons && !prev_br) begin
          chk("hold_valid", 64'(fetch_valid), 64'd1);
          chk("hold_frozen", {PC_out[31:0], instruction}, {prev_pc[31:0], prev_ins});
          chk("hold_link", PC_branch_link, prev_link);
        end
`ifndef IFETCH_PREFETCH_EN
        if (fetch_valid) chk("no_req_in_hold", 64'(imem_req), 64'd0);
`endif
        if (fetch_valid && IF_ID_Write) begin
          n_consumed++;
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pc_out", PC_out, e.pc);
            chk("pc_link", PC_branch_link, e.pc + 64'd4);
            chk("instruction", 64'(instruction), 64'(e.ins));
          end
        end
        have_prev = 1'b1;
        prev_valid = fetch_valid;
        prev_cons = fetch_valid & IF_ID_Write;
        prev_br = branch_taken;
        prev_ins = instruction;
        prev_pc = PC_out;
        prev_link = PC_branch_link;
      end
    end
  end

  // Reference model: the consumed stream is sequential from the last redirect point.
  task automatic step(input logic wr, input logic br, input logic [63:0] tgt);
    @(posedge clock);
    #2;
    if (redirect_pending) begin
      exp_q.delete();
      gen_pc = redirect_tgt;
      redirect_pending = 1'b0;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, ins: mem_word(gen_pc)});
      gen_pc = gen_pc + 64'd4;
    end
    IF_ID_Write = wr;
    branch_taken = br;
    branch_target = tgt;
    if (br) begin
      redirect_pending = 1'b1;
      redirect_tgt = {tgt[63:2], 2'b00};
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    gen_pc = RST_PC;
    redirect_pending = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    if (!imem_req) chk(name, 64'd0, 64'd1);
  endtask

  task automatic async_reset_mid_cycle();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_req_drop", 64'(imem_req), 64'd0);
    chk("rst_valid_drop", 64'(fetch_valid), 64'd0);
    chk("rst_pc_out", PC_out, 64'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin : stimulus
    logic        br, prev_br;
    logic [63:0] tgt;
    int          c0, n;

    // Reset state
    #3;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_pc_out", PC_out, 64'd0);
    chk("rst_pc_link", PC_branch_link, 64'd0);
    @(posedge clock);
    #2;
    model_reset();
    reset = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, RST_PC);

    // Sequential fetch with 0-wait memory, then throughput window
    repeat (12) step(1'b1, 1'b0, '0);
    c0 = n_consumed;
    repeat (20) step(1'b1, 1'b0, '0);
`ifdef IFETCH_PREFETCH_EN
    chk("throughput", 64'(n_consumed - c0), 64'd20);
`else
    chk("throughput", 64'(n_consumed - c0), 64'd10);
`endif

    // Stall while a fetch is presented
    n = 0;
    step(1'b0, 1'b0, '0);
    while (!fetch_valid && n < 20) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    chk("stall_reached_valid", 64'(fetch_valid), 64'd1);
    repeat (5) step(1'b0, 1'b0, '0);
    repeat (10) step(1'b1, 1'b0, '0);

    // Branch during a 3-wait request
    max_wait = 3;
    n = 0;
    step(1'b1, 1'b0, '0);
    while (!(imem_req && !imem_ack) && n < 50) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    chk("midwait_found", 64'(imem_req && !imem_ack), 64'd1);
    step(1'b1, 1'b1, 64'h2003);
    repeat (30) step(1'b1, 1'b0, '0);

    // Branch in the same cycle as the memory acknowledge
    max_wait = 2;
    n = 0;
    step(1'b1, 1'b0, '0);
    while (!(imem_req && imem_ack) && n < 50) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    chk("ack_found", 64'(imem_req && imem_ack), 64'd1);
    step(1'b1, 1'b1, 64'h3000);
    repeat (30) step(1'b1, 1'b0, '0);

    // PC wrap-around
    max_wait = 0;
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (16) step(1'b1, 1'b0, '0);

    // Randomised traffic
    prev_br = 1'b0;
    for (int phase = 0; phase < 4; phase++) begin
      max_wait = phase;
      for (int i = 0; i < 200; i++) begin
        br = !prev_br && ($urandom_range(19, 0) == 0);
        case ($urandom_range(3, 0))
          0:       tgt = 64'h2003;
          1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
          2:       tgt = {32'h0, $urandom};
          default: tgt = {$urandom, $urandom};
        endcase
        step($urandom_range(3, 0) != 0, br, tgt);
        prev_br = br;
      end
    end
    step(1'b1, 1'b0, '0);

    // Asynchronous reset while a request is pending, then while a fetch is presented
    max_wait = 3;
    wait_req("req_before_reset");
    async_reset_mid_cycle();
    repeat (20) step(1'b1, 1'b0, '0);
    n = 0;
    step(1'b0, 1'b0, '0);
    while (!fetch_valid && n < 30) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    chk("valid_before_reset", 64'(fetch_valid), 64'd1);
    async_reset_mid_cycle();
    max_wait = 0;
    repeat (20) step(1'b1, 1'b0, '0);

    step(1'b0, 1'b0, '0);
    chk("progress", 64'(n_consumed > 150), 64'd1);
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
